load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set data width, address width, and memory depth of 2**WIDTH words.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on posedge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req_valid  input  1  core access request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_address  input  WIDTH  word address of access.
REQ-008 req_wdata  input  WIDTH  store data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  core accepts response.
REQ-011 rsp_rdata  output  WIDTH  load data; for stores, the stored data.
REQ-012 rsp_error  output  1  write-verify mismatch (0 when feature is compiled out).
REQ-013 txn_count  output  WIDTH  completed-transaction counter.
REQ-014 memory_write_enable  output  1  write strobe to Data_Memory.
REQ-015 address_rw  output  WIDTH  memory address.
REQ-016 data_in  output  WIDTH  memory write data.
REQ-017 data_out  input  WIDTH  combinational memory read data.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, VERIFY, and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid && req_ready at posedge.
REQ-020 On handshake, the unit SHALL latch write, address, and wdata and enter ACCESS; otherwise it SHALL stay in IDLE.
REQ-021 ACCESS SHALL last exactly one cycle: address_rw = latched address, data_in = latched wdata, memory_write_enable = latched write.
REQ-022 On a load in ACCESS, the unit SHALL capture data_out into the response register at the closing edge and go to RESP.
REQ-023 On a store in ACCESS, the unit SHALL load latched wdata into the response register and go to RESP (VERIFY when the feature is enabled).
REQ-024 memory_write_enable SHALL be 0 in every state except ACCESS-with-store; address_rw and data_in SHALL be 0 in IDLE and RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_error SHALL be held stable until rsp_valid && rsp_ready, after which the unit returns to IDLE.
REQ-026 Latency SHALL be: handshake at edge N, rsp_valid high from edge N+2 (N+3 with verify).
REQ-027 Back-to-back operation: the next request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-028 A new request SHALL NOT be accepted while a response is pending, since req_ready is 0 outside IDLE.
REQ-029 txn_count SHALL increment by 1 on each response handshake and wrap from 2**WIDTH-1 to 0.
REQ-030 Inputs req_* SHALL be ignored outside the IDLE handshake cycle; changes after acceptance SHALL have no effect.

Reset
REQ-031 Reset SHALL asynchronously force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, txn_count = 0, memory_write_enable = 0, address_rw = 0, and data_in = 0.
REQ-032 Reset asserted during ACCESS SHALL drop memory_write_enable immediately; the in-flight transaction SHALL be discarded without a response.

Configuration
REQ-033 With LSU_WRITE_VERIFY_EN defined, a store SHALL pass through VERIFY for one cycle (address_rw = latched address, memory_write_enable = 0) and set rsp_error = (data_out != latched wdata).
REQ-034 Without LSU_WRITE_VERIFY_EN, the VERIFY state SHALL be unreachable, stores SHALL go ACCESS->RESP, and rsp_error SHALL be tied to 0.
REQ-035 Loads SHALL never enter VERIFY and SHALL return rsp_error = 0 in both configurations.

Structure
REQ-036 The state enum typedef (lsu_state_t) and its encoding width constant SHALL live in shared package lsu_pkg.
REQ-037 No sub-module SHALL be used; FSM, request latch, response register, and counter SHALL reside in load_store_unit; the bench SHALL connect it to a Data_Memory instance of equal WIDTH.

Verification
REQ-038 Scenario: store addr 0x10 data 0xA5, then load 0x10 -> rsp_rdata = 0xA5 both times; memory_write_enable high for exactly 1 cycle.
REQ-039 Scenario: load request at edge N with rsp_ready held 1 -> rsp_valid rises at N+2 (N+3 for a store with verify); req_ready = 0 from N to response handshake.
REQ-040 Scenario: rsp_ready held 0 for 5 cycles during RESP -> rsp_valid and rsp_rdata stable; req_ready = 0; no memory write.
REQ-041 Scenario: with verify enabled, force a Data_Memory word to 0x00 after store of 0x3C -> rsp_error = 1; normal store -> rsp_error = 0.
REQ-042 Scenario: 256 transactions with WIDTH = 8 -> txn_count wraps to 0; reset asserted mid-ACCESS store -> memory_write_enable = 0 same cycle, no response, target word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding.
package lsu_pkg;

   localparam int LSU_STATE_W = 2;

   typedef enum logic [LSU_STATE_W-1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      VERIFY = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/Data_Memory.sv
// Single-port word memory: synchronous write, combinational read.
module Data_Memory #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             memory_write_enable,
   input  logic [WIDTH-1:0] address_rw,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] mem [2**WIDTH];

   always_ff @(posedge clk) begin
      if (memory_write_enable) begin
         mem[address_rw] <= data_in;
      end
   end

   assign data_out = mem[address_rw];

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and Data_Memory.
// Optional write-verify readback of stores is enabled with LSU_WRITE_VERIFY_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_address,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_error,
   output logic [WIDTH-1:0] txn_count,
   output logic             memory_write_enable,
   output logic [WIDTH-1:0] address_rw,
   output logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] data_out
);

   lsu_state_t       state;
   lsu_state_t       state_next;
   logic             write_q;
   logic [WIDTH-1:0] address_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] count_q;
   logic             handshake;

   assign handshake = req_valid && req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Memory-side outputs are decoded from state so reset drops them without waiting for an edge.
   always_comb begin
      state_next          = state;
      req_ready           = 1'b0;
      rsp_valid           = 1'b0;
      memory_write_enable = 1'b0;
      address_rw          = '0;
      data_in             = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            address_rw          = address_q;
            data_in             = wdata_q;
            memory_write_enable = write_q;
`ifdef LSU_WRITE_VERIFY_EN
            state_next          = write_q ? VERIFY : RESP;
`else
            state_next          = RESP;
`endif
         end
         VERIFY: begin
            address_rw = address_q;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_q   <= 1'b0;
         address_q <= '0;
         wdata_q   <= '0;
      end else if (handshake) begin
         write_q   <= req_write;
         address_q <= req_address;
         wdata_q   <= req_wdata;
      end
   end

   // Stores echo their own data so the core sees what was written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (state == ACCESS) begin
         rdata_q <= write_q ? wdata_q : data_out;
      end
   end

`ifdef LSU_WRITE_VERIFY_EN
   logic error_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (state == ACCESS) begin
         error_q <= 1'b0;
      end else if (state == VERIFY) begin
         error_q <= (data_out != wdata_q);
      end
   end

   assign rsp_error = error_q;
`else
   assign rsp_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (rsp_valid && rsp_ready) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign rsp_rdata = rdata_q;
   assign txn_count = count_q;

endmodule
